// File: rtl/aes_pkg.sv
// Shared AES definitions: column count, S-box lookup, GF(2^8) xtime and the
// encryption FSM state encoding. The S-box here is the one copy used by both the
// cipher datapath and the key-expansion stage.
package aes_pkg;

  localparam int unsigned Nb = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } aes_state_e;

  // Forward S-box, entry x at bits [8*x +: 8].
  localparam logic [0:2047] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTable[{x, 3'b000} +: 8];
  endfunction

  // Multiply by {02} in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round.
//   state_i : current state, byte k (row k%4, column k/4) at bits [8*k +: 8]
//   rkey_i  : round key, same byte ordering
//   last_i  : final round, MixColumns skipped
//   state_o : SubBytes -> ShiftRows -> MixColumns -> AddRoundKey result
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] rkey_i,
  input  logic         last_i,
  output logic [0:127] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    for (int k = 0; k < 16; k++) begin
      sb[k] = sbox(state_i[8*k +: 8]);
    end
    // Row r rotates left by r columns: new (r, c) takes old (r, (c + r) mod 4).
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int k = 0; k < 16; k++) begin
      state_o[8*k +: 8] = (last_i ? sr[k] : mc[k]) ^ rkey_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock, Nr cycles from accept to result.
//   clk, reset           : clock and synchronous active-high reset
//   in_valid / in_ready  : plaintext handshake (in_ready only in IDLE)
//   in_block             : plaintext, byte s0,0 in bits [0:7], column-major
//   Word                 : expanded key schedule, round key r at [128*r +: 128]
//   out_valid / out_ready: ciphertext handshake, result held until taken
//   out_block            : ciphertext, driven straight from the state register
//   busy                 : high while a block is in ROUND or DONE
module aes_cipher_iter #(
  parameter int unsigned Nb = 4,
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:127]            in_block,
  input  logic [0:32*Nb*(Nr+1)-1] Word,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:127]            out_block,
  output logic                    busy
);
  import aes_pkg::*;

  if (Nb != aes_pkg::Nb || Nr != Nk + 6) begin : g_bad_cfg
    $error("aes_cipher_iter: unsupported Nb/Nk/Nr combination");
  end

  localparam logic [3:0] LastRnd = 4'(Nr);

  aes_state_e   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] blk_q, blk_d;
  logic [3:0]   rkey_idx;
  logic [0:127] rkey;
  logic [0:127] round_out;
  logic         last;

  // Outside ROUND only key 0 is needed (initial AddRoundKey), which also keeps
  // the select in range once rnd has stepped past Nr.
  assign rkey_idx = (state_q == StRound) ? rnd_q : 4'd0;
  assign rkey     = Word[128*rkey_idx +: 128];
  assign last     = (rnd_q == LastRnd);

  aes_round u_round (
    .state_i (blk_q),
    .rkey_i  (rkey),
    .last_i  (last),
    .state_o (round_out)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          blk_d   = in_block ^ rkey;
          rnd_d   = 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        blk_d = round_out;
        rnd_d = rnd_q + 4'd1;
        if (last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRound) || (state_q == StDone);
  assign out_block = blk_q;

endmodule
